// File: rtl/round_ctrl_if.sv
// Game-round bus between the score evaluator side and round_ctrl.
// The master (evaluator/front panel) drives start and score.
// The slave (round_ctrl) returns phase, scores, point pulse and winner.
interface round_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic [1:0]         score;
  logic               score_en;
  logic [1:0]         phase;
  logic [SCORE_W-1:0] red_score;
  logic [SCORE_W-1:0] blue_score;
  logic [1:0]         point;
  logic [1:0]         winner;

  modport master (
    output start, score,
    input  score_en, phase, red_score, blue_score, point, winner
  );

  modport slave (
    input  start, score,
    output score_en, phase, red_score, blue_score, point, winner
  );
endinterface

// File: rtl/round_ctrl.sv
// Game-round sequencer: edge-qualifies one-hot {red, blue} score requests,
// keeps per-player point counters and steps IDLE -> PLAY -> PAUSE/OVER.
module round_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 4,
  parameter int PAUSE_CYCLES = 1000,
  parameter int PAUSE_W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  round_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [SCORE_W-1:0] LP_WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] LP_PAUSE = PAUSE_W'(PAUSE_CYCLES - 1);

  state_t             r_state;
  logic [1:0]         r_score_q;
  logic [SCORE_W-1:0] r_red;
  logic [SCORE_W-1:0] r_blue;
  logic [1:0]         r_point;
  logic [1:0]         r_winner;
  logic [PAUSE_W-1:0] r_cnt;

  logic               w_new_req;
  logic [SCORE_W-1:0] w_red_inc;
  logic [SCORE_W-1:0] w_blue_inc;

  // Rising-edge qualification of a legal one-hot request plus next counter values
  always_comb begin
    w_new_req  = ((bus.score == 2'b10) || (bus.score == 2'b01)) && (r_score_q == 2'b00);
    w_red_inc  = r_red + 1'b1;
    w_blue_inc = r_blue + 1'b1;
  end

  // Round state machine with registered scores, point pulse and winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_score_q <= '0;
      r_red     <= '0;
      r_blue    <= '0;
      r_point   <= '0;
      r_winner  <= '0;
      r_cnt     <= '0;
    end else begin
      r_score_q <= bus.score;
      r_point   <= '0;
      case (r_state)
        IDLE, OVER: begin
          if (bus.start) begin
            r_state  <= PLAY;
            r_red    <= '0;
            r_blue   <= '0;
            r_winner <= '0;
          end
        end
        PLAY: begin
          if (w_new_req) begin
            if (bus.score[1]) begin
              r_red   <= w_red_inc;
              r_point <= 2'b10;
              if (w_red_inc == LP_WIN) begin
                r_state  <= OVER;
                r_winner <= 2'b10;
              end else begin
                r_state <= PAUSE;
                r_cnt   <= LP_PAUSE;
              end
            end else begin
              r_blue  <= w_blue_inc;
              r_point <= 2'b01;
              if (w_blue_inc == LP_WIN) begin
                r_state  <= OVER;
                r_winner <= 2'b01;
              end else begin
                r_state <= PAUSE;
                r_cnt   <= LP_PAUSE;
              end
            end
          end
        end
        PAUSE: begin
          if (r_cnt == '0) begin
            r_state <= PLAY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.score_en   = (r_state == PLAY);
  assign bus.phase      = r_state;
  assign bus.red_score  = r_red;
  assign bus.blue_score = r_blue;
  assign bus.point      = r_point;
  assign bus.winner     = r_winner;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: instance A (3-cycle pause) covers reset,
// scoring, edge qualification, win and restart; instance B (1000-cycle
// pause) covers reset in the middle of a long pause.
module tb_round_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   vectors;
  int   miscompares;

  round_ctrl_if #(.SCORE_W(4)) bus_a ();
  round_ctrl_if #(.SCORE_W(4)) bus_b ();

  round_ctrl #(
    .WIN_SCORE   (5),
    .SCORE_W     (4),
    .PAUSE_CYCLES(3),
    .PAUSE_W     (2)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  round_ctrl #(
    .WIN_SCORE   (5),
    .SCORE_W     (4),
    .PAUSE_CYCLES(1000),
    .PAUSE_W     (10)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b1;
    bus_a.score = 2'b10;
    bus_b.start = 1'b0;
    bus_b.score = 2'b00;

    // Reset dominates start and score
    tick();
    tick();
    check("rst_phase",  8'(bus_a.phase),      8'h0);
    check("rst_red",    8'(bus_a.red_score),  8'h0);
    check("rst_blue",   8'(bus_a.blue_score), 8'h0);
    check("rst_point",  8'(bus_a.point),      8'h0);
    check("rst_winner", 8'(bus_a.winner),     8'h0);
    check("rst_en",     8'(bus_a.score_en),   8'h0);

    // Start game
    rst_a = 1'b0;
    bus_a.start = 1'b1;
    bus_a.score = 2'b00;
    tick();
    check("start_phase", 8'(bus_a.phase),    8'h1);
    check("start_en",    8'(bus_a.score_en), 8'h1);
    bus_a.start = 1'b0;

    // Red event held high for 5 cycles: one point only
    bus_a.score = 2'b10;
    tick();
    check("red1_score", 8'(bus_a.red_score), 8'h1);
    check("red1_point", 8'(bus_a.point),     8'h2);
    check("red1_phase", 8'(bus_a.phase),     8'h2);
    check("red1_en",    8'(bus_a.score_en),  8'h0);
    tick();
    check("pause1_phase", 8'(bus_a.phase), 8'h2);
    check("pause1_point", 8'(bus_a.point), 8'h0);
    tick();
    check("pause2_phase", 8'(bus_a.phase), 8'h2);
    tick();
    check("pause_end_phase", 8'(bus_a.phase), 8'h1);
    tick();
    check("held_red",   8'(bus_a.red_score), 8'h1);
    check("held_point", 8'(bus_a.point),     8'h0);

    // Release then re-press
    bus_a.score = 2'b00;
    tick();
    bus_a.score = 2'b10;
    tick();
    check("red2_score", 8'(bus_a.red_score), 8'h2);
    check("red2_phase", 8'(bus_a.phase),     8'h2);

    // Blue request arriving during pause is ignored and not counted after
    bus_a.score = 2'b00;
    tick();
    bus_a.score = 2'b01;
    tick();
    tick();
    check("pause_blue_phase", 8'(bus_a.phase),      8'h1);
    check("pause_blue_score", 8'(bus_a.blue_score), 8'h0);
    check("pause_blue_point", 8'(bus_a.point),      8'h0);

    // Illegal 11 in PLAY
    bus_a.score = 2'b00;
    tick();
    bus_a.score = 2'b11;
    tick();
    check("ill_red",   8'(bus_a.red_score),  8'h2);
    check("ill_blue",  8'(bus_a.blue_score), 8'h0);
    check("ill_point", 8'(bus_a.point),      8'h0);
    check("ill_phase", 8'(bus_a.phase),      8'h1);

    // Blue runs to 5
    bus_a.score = 2'b00;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus_a.score = 2'b01;
      tick();
      check("blue_score", 8'(bus_a.blue_score), 8'(i));
      check("blue_point", 8'(bus_a.point),      8'h1);
      if (i < 5) begin
        check("blue_phase", 8'(bus_a.phase), 8'h2);
        bus_a.score = 2'b00;
        tick();
        tick();
        tick();
        check("blue_replay", 8'(bus_a.phase), 8'h1);
      end
    end
    check("win_phase",  8'(bus_a.phase),    8'h3);
    check("win_winner", 8'(bus_a.winner),   8'h1);
    check("win_en",     8'(bus_a.score_en), 8'h0);

    // Events after game over are ignored
    bus_a.score = 2'b00;
    tick();
    bus_a.score = 2'b10;
    tick();
    check("over_red",    8'(bus_a.red_score),  8'h2);
    check("over_blue",   8'(bus_a.blue_score), 8'h5);
    check("over_point",  8'(bus_a.point),      8'h0);
    check("over_phase",  8'(bus_a.phase),      8'h3);
    check("over_winner", 8'(bus_a.winner),     8'h1);

    // Restart from OVER, then first event right after start
    bus_a.score = 2'b00;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check("restart_phase",  8'(bus_a.phase),      8'h1);
    check("restart_red",    8'(bus_a.red_score),  8'h0);
    check("restart_blue",   8'(bus_a.blue_score), 8'h0);
    check("restart_winner", 8'(bus_a.winner),     8'h0);
    bus_a.score = 2'b10;
    tick();
    check("first_ev_red", 8'(bus_a.red_score), 8'h1);

    // Reset in the middle of a 1000-cycle pause (counter at 500)
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    bus_b.score = 2'b10;
    tick();
    check("b_red1", 8'(bus_b.red_score), 8'h1);
    bus_b.score = 2'b00;
    for (int k = 0; k < 499; k++) tick();
    check("b_mid_phase", 8'(bus_b.phase), 8'h2);
    rst_b = 1'b1;
    tick();
    check("b_rst_phase",  8'(bus_b.phase),     8'h0);
    check("b_rst_red",    8'(bus_b.red_score), 8'h0);
    check("b_rst_point",  8'(bus_b.point),     8'h0);
    check("b_rst_winner", 8'(bus_b.winner),    8'h0);
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    check("b_resume_phase", 8'(bus_b.phase), 8'h1);
    bus_b.score = 2'b01;
    tick();
    check("b_blue1",  8'(bus_b.blue_score), 8'h1);
    check("b_bpoint", 8'(bus_b.point),      8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Game-round sequencer sitting downstream of the combinational score evaluator. Accepts its one-hot `{red, blue}` score request, edge-qualifies it, and keeps per-player point counters. Sequences the round through idle, play, post-point pause and game-over, and drives the enable that gates the evaluator and the display of scores and winner. Clocked design; one point per accepted event, never more.

## Interface

Parameters:
- `WIN_SCORE`, 5: points needed to win; must satisfy 1 ≤ WIN_SCORE ≤ 2^SCORE_W − 1.
- `SCORE_W`, 4: width of each score counter.
- `PAUSE_CYCLES`, 1000: pause length after a non-winning point, in clocks (1 s at 1 kHz); must be ≥ 1.
- `PAUSE_W`, 10: pause counter width; must hold PAUSE_CYCLES − 1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: level, sampled each clock; begins a new game.
- `score`, input, 2: `{scr, scb}` from the evaluator; 10 = red point, 01 = blue point.
- `score_en`, output, 1: high exactly while in PLAY; gates evaluator inputs upstream.
- `phase`, output, 2: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER.
- `red_score`, output, SCORE_W: red points.
- `blue_score`, output, SCORE_W: blue points.
- `point`, output, 2: one-cycle `{red, blue}` pulse when a point is awarded.
- `winner`, output, 2: 10 red won, 01 blue won, 00 none; valid in OVER.

## Operation

- **Reset (`rst` = 1):** phase = IDLE, both scores 0, `point` = 00, `winner` = 00, pause counter 0, `score_q` = 00. Reset wins over every other input in the same cycle, including mid-pause and mid-game.
- **Score history register:** `score_q` samples `score` every clock, in every state.
- **Accepted event:** in PLAY, `score` ∈ {10, 01} and `score_q` == 00.
  - 11 is illegal and ignored.
  - A level held high counts once.
  - A level still high when PAUSE ends does not count again; `score` must return to 00 first.
- **IDLE:** `start` → PLAY; scores cleared to 0 and `winner` cleared to 00 on that edge. `score` ignored.
- **PLAY:** on an accepted event, the matching score increments and `point` pulses the matching bit. Then:
  - New value == WIN_SCORE → OVER, with `winner` set to the matching bit.
  - Otherwise → PAUSE, with pause counter loaded with PAUSE_CYCLES − 1.
  - `start` is ignored.
- **PAUSE:** counter decrements each clock. When it reads 0, next state is PLAY. `score` and `start` are ignored.
- **OVER:** scores and `winner` hold. `start` → PLAY with scores and `winner` cleared, same as from IDLE.
- **Counter width:** counters never exceed WIN_SCORE, so no wrap is possible. Increment is SCORE_W-bit unsigned.

## Timing

- All outputs are registered.
- **Event latency:** event sampled at edge N. At edge N+1, the score register is updated, `point` goes high for one cycle, and `phase` updates. `score_en` drops at N+1.
- **Pause length:** PAUSE lasts exactly PAUSE_CYCLES clocks. With PAUSE_CYCLES = 1, PAUSE is one cycle.
- **Start latency:** `start` sampled at edge N gives `phase` = 01 and cleared scores at N+1. The first accepted event can be sampled at N+1 if `score_q` == 00.
- **`score_en`** is a function of the registered phase only: `score_en` = (`phase` == 01).
- **`point`** is 00 in every cycle without an award, including the cycle after reset.

## Test plan

1. **Reset values:** assert `rst` 2 cycles with `score` = 10 and `start` = 1. Required: `phase` 00, scores 0/0, `point` 00, `winner` 00, `score_en` 0.
2. **Single point and pause:** `start` for 1 cycle, then hold `score` = 10 for 5 cycles. Required: `red_score` = 1 exactly once and `point` = 10 for 1 cycle. Then `phase` 10 for PAUSE_CYCLES clocks, returning to 01. No second point while 10 is still held; 00 then 10 gives `red_score` 2.
3. **Illegal and ignored inputs:** in PLAY, drive `score` = 11. Required: no change. During PAUSE, drive 00→01. Required: `blue_score` unchanged.
4. **Win:** alternate valid blue events separated by 00 and by pauses (PAUSE_CYCLES = 3) until blue reaches 5. Required: `phase` 11, `winner` 01, `blue_score` 5. Further events are ignored.
5. **Restart from OVER:** `start` in OVER. Required: next cycle `phase` 01, scores 0/0, `winner` 00.
6. **Reset mid-pause:** `rst` asserted with pause counter = 500. Required: IDLE, all zero on the next cycle; `start` afterwards resumes normally.
